payment_change_controller: RTL

Top-level sale sequencer for the barcode-reader vending path. Latches the scanned price, accumulates inserted money (2/10/20 euro), and computes the change. Starts the change dispenser (5-bit euro amount in, one-cycle done pulse back) exactly once per sale. Handles cancel, over-insertion reject and optional inactivity refund.

---
 rtl/payment_pkg.sv | 25 ++
 rtl/payment_timeout_timer.sv | 29 ++
 rtl/payment_change_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/payment_pkg.sv
// Shared encodings for the vending sale sequencer: FSM states, denominations and money limits.
// Used by payment_change_controller and, under TIMEOUT_REFUND_EN, payment_timeout_timer.
package payment_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COLLECT   = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DISP = 3'd3,
    ST_FINISH    = 3'd4
  } state_e;

  localparam logic [4:0] COIN2_VAL  = 5'd2;
  localparam logic [4:0] NOTE10_VAL = 5'd10;
  localparam logic [4:0] NOTE20_VAL = 5'd20;

  localparam logic [4:0] MAX_PRICE = 5'd28;
  // Dispenser ceiling; kept 6 bits wide so the running total compare cannot wrap.
  localparam logic [5:0] MAX_TOTAL = 6'd30;

  function automatic logic price_legal(input logic [4:0] p);
    return (p != 5'd0) && !p[0] && (p <= MAX_PRICE);
  endfunction

endpackage

// File: rtl/payment_timeout_timer.sv
// Inactivity counter for the COLLECT state; only instantiated when TIMEOUT_REFUND_EN is defined.
// expired_o fires during the TIMEOUT_CYCLES-th consecutive counted cycle.
module payment_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ONE  = TIMER_W'(1);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (count_i) begin
      count_q <= count_q + ONE;
    end
  end

  assign expired_o = count_i && (count_q == LAST);

endmodule

// File: rtl/payment_change_controller.sv
// Sale sequencer: latches price, accumulates money, starts the change dispenser once per sale.
// Define TIMEOUT_REFUND_EN to add an inactivity auto-refund in COLLECT.
module payment_change_controller
  import payment_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 10
)
(
  input  logic       clock,
  input  logic       reset,
  input  logic       priceValid,
  input  logic [4:0] price,
  input  logic       coin2In,
  input  logic       note10In,
  input  logic       note20In,
  input  logic       cancel,
  input  logic       dispNoMoneyLeft,
  output logic [4:0] moneyToGive,
  output logic [4:0] paidTotal,
  output logic       insertReject,
  output logic       priceError,
  output logic       saleDone,
  output logic       refundDone,
  output logic       busy,
  output logic [2:0] state
);

  state_e     state_q, state_d;
  logic [4:0] price_q, price_d, paid_q, paid_d, give_q, give_d;
  logic       rej_q, rej_d, perr_q, perr_d, sale_q, sale_d, refund_q, refund_d;
  logic       is_sale_q, is_sale_d, busy_q;

  logic       any_ins, multi_ins, fits, accept, timeout, go_refund;
  logic [4:0] ins_val, change;
  logic [5:0] new_total;

  // Highest denomination wins; anything lower in the same cycle is dropped.
  always_comb begin
    any_ins   = note20In | note10In | coin2In;
    multi_ins = (note20In & (note10In | coin2In)) | (note10In & coin2In);
    if (note20In)      ins_val = NOTE20_VAL;
    else if (note10In) ins_val = NOTE10_VAL;
    else if (coin2In)  ins_val = COIN2_VAL;
    else               ins_val = '0;
    new_total = {1'b0, paid_q} + {1'b0, ins_val};
    fits      = (new_total <= MAX_TOTAL);
    change    = new_total[4:0] - price_q;
    accept    = (state_q == ST_COLLECT) && !cancel && any_ins && fits;
  end

`ifdef TIMEOUT_REFUND_EN
  payment_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMER_W       (TIMER_W)
  ) u_timer (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  ((state_q != ST_COLLECT) || accept),
    .count_i  (state_q == ST_COLLECT),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    price_d   = price_q;
    paid_d    = paid_q;
    give_d    = '0;
    rej_d     = any_ins;
    perr_d    = 1'b0;
    sale_d    = 1'b0;
    refund_d  = 1'b0;
    is_sale_d = is_sale_q;
    go_refund = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (priceValid) begin
          if (price_legal(price)) begin
            price_d = price;
            state_d = ST_COLLECT;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        // Cancel beats insertion; an accepted insertion beats the timeout.
        if (cancel) begin
          go_refund = 1'b1;
        end else if (accept) begin
          paid_d = new_total[4:0];
          rej_d  = multi_ins;
          if (new_total >= {1'b0, price_q}) begin
            is_sale_d = 1'b1;
            if (change != 5'd0) begin
              give_d  = change;
              state_d = ST_START;
            end else begin
              sale_d  = 1'b1;
              state_d = ST_FINISH;
            end
          end
        end else if (timeout) begin
          go_refund = 1'b1;
        end
        if (go_refund) begin
          is_sale_d = 1'b0;
          if (paid_q != 5'd0) begin
            give_d  = paid_q;
            state_d = ST_START;
          end else begin
            refund_d = 1'b1;
            state_d  = ST_FINISH;
          end
        end
      end
      // give_d defaults to 0, so the dispenser sees the amount for exactly one cycle.
      ST_START: state_d = ST_WAIT_DISP;
      ST_WAIT_DISP: begin
        if (dispNoMoneyLeft) begin
          state_d  = ST_FINISH;
          sale_d   = is_sale_q;
          refund_d = !is_sale_q;
        end
      end
      ST_FINISH: begin
        paid_d  = '0;
        price_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      price_q   <= '0;
      paid_q    <= '0;
      give_q    <= '0;
      rej_q     <= 1'b0;
      perr_q    <= 1'b0;
      sale_q    <= 1'b0;
      refund_q  <= 1'b0;
      is_sale_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      price_q   <= price_d;
      paid_q    <= paid_d;
      give_q    <= give_d;
      rej_q     <= rej_d;
      perr_q    <= perr_d;
      sale_q    <= sale_d;
      refund_q  <= refund_d;
      is_sale_q <= is_sale_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign moneyToGive  = give_q;
  assign paidTotal    = paid_q;
  assign insertReject = rej_q;
  assign priceError   = perr_q;
  assign saleDone     = sale_q;
  assign refundDone   = refund_q;
  assign busy         = busy_q;
  assign state        = state_q;

endmodule
